// File: rtl/reminder_pkg.sv
// Shared definitions for the reminder scheduler: state encoding, grant bit
// positions, default timing and a few small decode helpers.
package reminder_pkg;

    localparam int ALARM_SEC_DEF  = 31;
    localparam int SNOOZE_SEC_DEF = 300;
    localparam int MAX_SNOOZE_DEF = 3;

    localparam int RUN_W = 8;
    localparam int SNZ_W = 9;

    localparam int GNT_CHIME = 0;
    localparam int GNT_ALARM = 1;
    localparam int GNT_TIMER = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHIME  = 3'd1,
        ST_ALARM  = 3'd2,
        ST_TIMER  = 3'd3,
        ST_SNOOZE = 3'd4
    } state_e;

    function automatic logic [2:0] grant_of(input state_e s);
        logic [2:0] g;
        g = '0;
        case (s)
            ST_CHIME: g[GNT_CHIME] = 1'b1;
            ST_ALARM: g[GNT_ALARM] = 1'b1;
            ST_TIMER: g[GNT_TIMER] = 1'b1;
            default:  g = '0;
        endcase
        return g;
    endfunction

    // Alarm and countdown share the "ringing" behaviour on the alarm lights.
    function automatic logic is_ring(input state_e s);
        return (s == ST_ALARM) || (s == ST_TIMER);
    endfunction

    function automatic logic uses_run(input state_e s);
        return (s == ST_CHIME) || (s == ST_ALARM) || (s == ST_TIMER);
    endfunction

endpackage

// File: rtl/sec_down_counter.sv
// Loadable seconds down-counter; holds at zero and flags it.
module sec_down_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/reminder_sched.sv
// Reminder scheduler: arbitrates hourly chime, alarm and countdown requests
// onto one light bank and buzzer, with limited snoozes for the alarm.
module reminder_sched
    import reminder_pkg::*;
#(
    parameter int ALARM_SEC  = ALARM_SEC_DEF,
    parameter int SNOOZE_SEC = SNOOZE_SEC_DEF,
    parameter int MAX_SNOOZE = MAX_SNOOZE_DEF
) (
    input  logic       CP_1Hz,
    input  logic       _CR,
    input  logic [7:0] show_hour,
    input  logic       req_chime,
    input  logic       req_alarm,
    input  logic       req_timer,
    input  logic       alarm_en,
    input  logic       key_stop,
    input  logic       key_snooze,
    output logic       start_light_hour,
    output logic       start_light_alarm,
    output logic       active_alarm,
    output logic       buzzer,
    output logic [2:0] grant,
    output logic       snoozing
);

    localparam int SCW = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);
    localparam logic [RUN_W-1:0] RUN_LOAD = RUN_W'(ALARM_SEC - 1);
    localparam logic [SNZ_W-1:0] SNZ_LOAD = SNZ_W'(SNOOZE_SEC - 1);
    localparam logic [SCW-1:0]   SNZ_MAX  = SCW'(MAX_SNOOZE);

    state_e state_q, state_d;

    logic pend_alarm_q, pend_alarm_d;
    logic pend_timer_q, pend_timer_d;
    logic pend_chime_q, pend_chime_d;
    logic take_alarm, take_timer, take_chime;
    logic alarm_ok, chime_ok, entering;

    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic [SCW-1:0]   snooze_cnt_q, snooze_cnt_d;

    logic             run_load, run_en, run_zero;
    logic [RUN_W-1:0] run_load_val;
    logic             snz_load, snz_en, snz_zero;

    logic       start_hour_q, start_hour_d;
    logic       start_alarm_q, start_alarm_d;
    logic       active_q, active_d;
    logic       buzzer_q, buzzer_d;
    logic [2:0] grant_q, grant_d;
    logic       snoozing_q, snoozing_d;

    assign alarm_ok = pend_alarm_q & alarm_en;
    assign chime_ok = pend_chime_q & (show_hour != 8'd0);

    // ---------------------------------------------------------------- state
    always_ff @(posedge CP_1Hz) begin
        // NOTE: sequential state uses <= so every register samples the
        // pre-edge values of its neighbours, independent of statement order.
        if (!_CR) begin
            state_q       <= ST_IDLE;
            start_hour_q  <= 1'b0;
            start_alarm_q <= 1'b0;
            active_q      <= 1'b0;
            buzzer_q      <= 1'b0;
            grant_q       <= 3'b000;
            snoozing_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_hour_q  <= start_hour_d;
            start_alarm_q <= start_alarm_d;
            active_q      <= active_d;
            buzzer_q      <= buzzer_d;
            grant_q       <= grant_d;
            snoozing_q    <= snoozing_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        take_alarm = 1'b0;
        take_timer = 1'b0;
        take_chime = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_CHIME: begin
                // A chime is preempted by the same priority grant IDLE uses.
                if (alarm_ok) begin
                    state_d    = ST_ALARM;
                    take_alarm = 1'b1;
                end else if (pend_timer_q) begin
                    state_d    = ST_TIMER;
                    take_timer = 1'b1;
                end else if (state_q == ST_IDLE) begin
                    if (chime_ok) begin
                        state_d    = ST_CHIME;
                        take_chime = 1'b1;
                    end
                end else if (run_zero) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ALARM: begin
                if (!alarm_en || key_stop) begin
                    state_d = ST_IDLE;
                end else if (key_snooze && (snooze_cnt_q < SNZ_MAX)) begin
                    state_d = ST_SNOOZE;
                end else if (run_zero) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SNOOZE: begin
                if (!alarm_en || key_stop) begin
                    state_d = ST_IDLE;
                end else if (alarm_ok) begin
                    state_d    = ST_ALARM;
                    take_alarm = 1'b1;
                end else if (snz_zero) begin
                    state_d = ST_ALARM;
                end
            end
            ST_TIMER: begin
                if (key_stop || run_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_comb begin
        entering     = (state_d != state_q);
        run_load     = entering && uses_run(state_d);
        run_load_val = (state_d == ST_CHIME) ? (show_hour - 8'd1) : RUN_LOAD;
        run_en       = uses_run(state_q);
        snz_load     = entering && (state_d == ST_SNOOZE);
        snz_en       = (state_q == ST_SNOOZE);

        run_cnt_d = run_cnt_q;
        if (entering && (state_d == ST_ALARM)) begin
            run_cnt_d = '0;
        end else if (state_q == ST_ALARM) begin
            run_cnt_d = run_cnt_q + RUN_W'(1);
        end

        snooze_cnt_d = snooze_cnt_q;
        if (state_d == ST_IDLE) begin
            snooze_cnt_d = '0;
        end else if (take_alarm && (state_q == ST_SNOOZE)) begin
            snooze_cnt_d = '0;
        end else if (snz_load) begin
            snooze_cnt_d = snooze_cnt_q + SCW'(1);
        end

        // A request for the source that currently owns the bank is dropped.
        pend_alarm_d = alarm_en &
                       ((pend_alarm_q & ~take_alarm) |
                        (req_alarm & (state_q != ST_ALARM)));
        pend_timer_d = (pend_timer_q & ~take_timer) |
                       (req_timer & (state_q != ST_TIMER));
        pend_chime_d = (show_hour != 8'd0) &
                       ((pend_chime_q & ~take_chime) |
                        (req_chime & (state_q != ST_CHIME) & (state_q != ST_SNOOZE)));
    end

    always_ff @(posedge CP_1Hz) begin
        if (!_CR) begin
            pend_alarm_q <= 1'b0;
            pend_timer_q <= 1'b0;
            pend_chime_q <= 1'b0;
            run_cnt_q    <= '0;
            snooze_cnt_q <= '0;
        end else begin
            pend_alarm_q <= pend_alarm_d;
            pend_timer_q <= pend_timer_d;
            pend_chime_q <= pend_chime_d;
            run_cnt_q    <= run_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
        end
    end

    // -------------------------------------------- outputs (from next state)
    always_comb begin
        grant_d       = grant_of(state_d);
        start_alarm_d = entering && is_ring(state_d);
        start_hour_d  = entering && (state_d == ST_CHIME);
        active_d      = is_ring(state_d);
        buzzer_d      = (state_d == ST_TIMER) || ((state_d == ST_ALARM) && run_cnt_d[0]);
        snoozing_d    = (state_d == ST_SNOOZE);
    end

    sec_down_counter #(.W(RUN_W)) u_run_cnt (
        .clk_i      (CP_1Hz),
        .rst_ni     (_CR),
        .load_i     (run_load),
        .load_val_i (run_load_val),
        .en_i       (run_en),
        .zero_o     (run_zero)
    );

    sec_down_counter #(.W(SNZ_W)) u_snz_cnt (
        .clk_i      (CP_1Hz),
        .rst_ni     (_CR),
        .load_i     (snz_load),
        .load_val_i (SNZ_LOAD),
        .en_i       (snz_en),
        .zero_o     (snz_zero)
    );

    assign start_light_hour  = start_hour_q;
    assign start_light_alarm = start_alarm_q;
    assign active_alarm      = active_q;
    assign buzzer            = buzzer_q;
    assign grant             = grant_q;
    assign snoozing          = snoozing_q;

endmodule

// File: tb/tb_reminder_sched.sv
// Self-checking bench for reminder_sched: directed scenarios plus random
// traffic, all compared cycle by cycle against a behavioural model.
module tb_reminder_sched;

    localparam int A_SEC = 31;
    localparam int S_SEC = 300;
    localparam int MAXS  = 3;

    logic       CP_1Hz = 1'b0;
    logic       _CR;
    logic [7:0] show_hour;
    logic       req_chime, req_alarm, req_timer, alarm_en, key_stop, key_snooze;
    logic       start_light_hour, start_light_alarm, active_alarm, buzzer, snoozing;
    logic [2:0] grant;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: activity name, cycles left in it, ring age, snoozes used.
    string m_mode  = "idle";
    int    m_left  = 0;
    int    m_age   = 0;
    int    m_snz   = 0;
    bit    m_pa    = 0;
    bit    m_pt    = 0;
    bit    m_pc    = 0;
    bit    m_fresh = 0;

    reminder_sched dut (
        .CP_1Hz            (CP_1Hz),
        ._CR               (_CR),
        .show_hour         (show_hour),
        .req_chime         (req_chime),
        .req_alarm         (req_alarm),
        .req_timer         (req_timer),
        .alarm_en          (alarm_en),
        .key_stop          (key_stop),
        .key_snooze        (key_snooze),
        .start_light_hour  (start_light_hour),
        .start_light_alarm (start_light_alarm),
        .active_alarm      (active_alarm),
        .buzzer            (buzzer),
        .grant             (grant),
        .snoozing          (snoozing)
    );

    always #5 CP_1Hz = ~CP_1Hz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_outs();
        return {start_light_hour, start_light_alarm, active_alarm, buzzer, snoozing, grant};
    endfunction

    function automatic logic [7:0] model_outs();
        logic [2:0] g;
        bit ring;
        g = (m_mode == "alarm") ? 3'b010 :
            (m_mode == "timer") ? 3'b100 :
            (m_mode == "chime") ? 3'b001 : 3'b000;
        ring = (m_mode == "alarm") || (m_mode == "timer");
        return {m_fresh && (m_mode == "chime"), m_fresh && ring, ring,
                (m_mode == "timer") || ((m_mode == "alarm") && (m_age % 2 == 1)),
                m_mode == "snooze", g};
    endfunction

    function automatic void model_step();
        string prev;
        string nxt;
        bit took_a, took_t, took_c;
        if (!_CR) begin
            m_mode = "idle"; m_left = 0; m_age = 0; m_snz = 0;
            m_pa = 0; m_pt = 0; m_pc = 0; m_fresh = 0;
            return;
        end
        prev = m_mode; nxt = m_mode;
        took_a = 0; took_t = 0; took_c = 0;
        if (prev == "idle" || prev == "chime") begin
            if (m_pa && alarm_en) begin nxt = "alarm"; took_a = 1; end
            else if (m_pt) begin nxt = "timer"; took_t = 1; end
            else if (prev == "idle") begin
                if (m_pc && show_hour != 0) begin nxt = "chime"; took_c = 1; end
            end else begin
                m_left--;
                if (m_left == 0) nxt = "idle";
            end
        end else if (prev == "alarm") begin
            if (!alarm_en || key_stop) nxt = "idle";
            else if (key_snooze && m_snz < MAXS) nxt = "snooze";
            else begin
                m_left--; m_age++;
                if (m_left == 0) nxt = "idle";
            end
        end else if (prev == "snooze") begin
            if (!alarm_en || key_stop) nxt = "idle";
            else if (m_pa) begin nxt = "alarm"; took_a = 1; m_snz = 0; end
            else begin
                m_left--;
                if (m_left == 0) nxt = "alarm";
            end
        end else begin
            if (key_stop) nxt = "idle";
            else begin
                m_left--;
                if (m_left == 0) nxt = "idle";
            end
        end
        m_fresh = 0;
        if (nxt != prev) begin
            if (nxt == "alarm") begin m_left = A_SEC; m_age = 0; m_fresh = 1; end
            else if (nxt == "timer") begin m_left = A_SEC; m_fresh = 1; end
            else if (nxt == "chime") begin m_left = int'(show_hour); m_fresh = 1; end
            else if (nxt == "snooze") begin m_left = S_SEC; m_snz++; end
        end
        if (nxt == "idle") m_snz = 0;
        m_pa = alarm_en && ((m_pa && !took_a) || (req_alarm && prev != "alarm"));
        m_pt = (m_pt && !took_t) || (req_timer && prev != "timer");
        m_pc = (show_hour != 0) &&
               ((m_pc && !took_c) || (req_chime && prev != "chime" && prev != "snooze"));
        m_mode = nxt;
    endfunction

    task automatic tick();
        @(posedge CP_1Hz);
        model_step();
        #1;
        check("model", dut_outs(), model_outs());
    endtask

    task automatic quiet_inputs();
        req_chime = 0; req_alarm = 0; req_timer = 0;
        key_stop = 0; key_snooze = 0; alarm_en = 1;
    endtask

    task automatic do_reset();
        _CR = 0;
        tick();
        _CR = 1;
    endtask

    initial begin
        int n_a, n_b, n_c, guard;
        _CR = 0; show_hour = 8'd0;
        quiet_inputs();
        do_reset();
        check("rst_outs", dut_outs(), 8'h00);

        // Chime at hour 3: one start pulse, three granted cycles.
        show_hour = 8'd3; req_chime = 1; tick(); req_chime = 0;
        tick();
        check("chime_first", {start_light_hour, grant}, 4'b1001);
        n_a = 1; n_b = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_a += start_light_hour;
            if (grant == 3'b001) n_b++;
        end
        check("chime_start_cnt", n_a, 1);
        check("chime_len", n_b, 3);
        check("chime_end", grant, 3'b000);

        // Hour 0 chime is discarded.
        show_hour = 8'd0; req_chime = 1; tick(); req_chime = 0;
        n_a = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (grant != 0) n_a++; end
        check("hour0_chime", n_a, 0);

        // Plain alarm ring.
        req_alarm = 1; tick(); req_alarm = 0;
        n_a = 0; n_b = 0; n_c = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_a += start_light_alarm; n_b += active_alarm; n_c += buzzer;
        end
        check("alarm_start_cnt", n_a, 1);
        check("alarm_len", n_b, A_SEC);
        check("alarm_buzz_cnt", n_c, A_SEC / 2);
        check("alarm_end", grant, 3'b000);

        // Three snoozes accepted, the fourth ignored.
        req_alarm = 1; tick(); req_alarm = 0; tick();
        check("snz_entry", start_light_alarm, 1);
        for (int k = 0; k < MAXS; k++) begin
            repeat (4) tick();
            key_snooze = 1; tick(); key_snooze = 0;
            check("snz_on", {snoozing, grant}, 4'b1000);
            n_a = 1; guard = 0;
            while (snoozing && guard < 400) begin
                tick(); guard++;
                if (snoozing) n_a++;
            end
            check("snz_len", n_a, S_SEC);
            check("snz_reentry", {start_light_alarm, grant}, 4'b1010);
        end
        repeat (4) tick();
        key_snooze = 1; tick(); key_snooze = 0;
        check("snz_4th_ignored", {snoozing, active_alarm}, 2'b01);
        key_stop = 1; tick(); key_stop = 0;
        check("alarm_stop", grant, 3'b000);

        // Alarm preempts a running chime; the chime is not resumed.
        show_hour = 8'd12; req_chime = 1; tick(); req_chime = 0;
        tick(); tick(); tick();
        req_alarm = 1; tick(); req_alarm = 0;
        check("chime_hold", grant, 3'b001);
        tick();
        check("preempt", {start_light_alarm, grant}, 4'b1010);
        key_stop = 1; tick(); key_stop = 0;
        n_a = 0;
        for (int i = 0; i < 15; i++) begin tick(); if (start_light_hour || grant == 3'b001) n_a++; end
        check("chime_dropped", n_a, 0);

        // Alarm wins over a simultaneous timer; timer follows the stop.
        req_timer = 1; req_alarm = 1; tick(); req_timer = 0; req_alarm = 0;
        tick();
        check("alarm_first", grant, 3'b010);
        repeat (3) tick();
        key_stop = 1; tick(); key_stop = 0;
        check("after_stop", grant, 3'b000);
        tick();
        check("timer_start", {start_light_alarm, grant, buzzer}, 5'b11001);
        key_snooze = 1; tick(); key_snooze = 0;
        check("timer_no_snooze", {snoozing, grant}, 4'b0100);
        n_a = 2; n_b = 2;
        for (int i = 0; i < 40; i++) begin tick(); n_a += active_alarm; n_b += buzzer; end
        check("timer_len", n_a, A_SEC);
        check("timer_buzz", n_b, A_SEC);

        // Disabling the alarm ends the ring and drops new alarm requests.
        req_alarm = 1; tick(); req_alarm = 0; repeat (4) tick();
        alarm_en = 0; tick();
        check("en_off", {active_alarm, grant}, 4'b0000);
        req_alarm = 1; tick(); req_alarm = 0; tick();
        alarm_en = 1;
        n_a = 0;
        for (int i = 0; i < 5; i++) begin tick(); n_a += start_light_alarm; end
        check("en_off_drop", n_a, 0);

        // Reset mid-ring clears everything, including pending requests.
        req_alarm = 1; tick(); req_alarm = 0; repeat (5) tick();
        req_timer = 1; tick(); req_timer = 0;
        show_hour = 8'd5; req_chime = 1; tick(); req_chime = 0;
        _CR = 0; tick();
        check("rst_mid", dut_outs(), 8'h00);
        _CR = 1;
        n_a = 0;
        for (int i = 0; i < 10; i++) begin tick(); n_a += start_light_alarm + start_light_hour; end
        check("no_start_after_rst", n_a, 0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            req_chime  = ($urandom_range(0, 19) == 0);
            req_alarm  = ($urandom_range(0, 39) == 0);
            req_timer  = ($urandom_range(0, 39) == 0);
            key_stop   = ($urandom_range(0, 29) == 0);
            key_snooze = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) alarm_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) show_hour = 8'($urandom_range(0, 23));
            _CR = ($urandom_range(0, 499) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
